// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential sign-magnitude adder/subtractor:
// ALU opcodes and FSM state encoding.
package addsub_pkg;

  localparam logic [3:0] ADDPP = 4'b1000;
  localparam logic [3:0] ADDPN = 4'b1001;
  localparam logic [3:0] ADDNP = 4'b1010;
  localparam logic [3:0] ADDNN = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/addsub_seq_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out; reused every
// ADD cycle by addsub_seq.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq.sv
// Sequential sign-magnitude adder/subtractor, CHUNK bits per cycle.
// Optional macro ADDSUB_SAT_EN: saturate C to all ones on overflow (default wraps).
//
// state | meaning
// IDLE  | waiting for start; operands captured as two's complement on start
// ADD   | one chunk of opA+opB+carry per cycle, NCHUNK cycles
// NORM  | convert two's complement sum to sign + magnitude, set flags
// DONE  | finish pulse for one cycle
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             finish,
  output logic             sign,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] C
);

  localparam int W2     = WIDTH + 2;
  localparam int NCHUNK = (W2 + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state_q, state_d;
  logic [PW-1:0]     op_a_q, op_a_d;
  logic [PW-1:0]     op_b_q, op_b_d;
  logic [W2-1:0]     sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ill_op_q, ill_op_d;
  logic              sign_q, sign_d;
  logic              overflow_q, overflow_d;
  logic              illegal_q, illegal_d;
  logic [WIDTH-1:0]  c_q, c_d;

  logic [W2-1:0]     a_ext, b_ext, op_a_cap, op_b_cap;
  logic [CHUNK-1:0]  chunk_s;
  logic              chunk_cout;
  logic [W2-1:0]     sum_ins;
  logic [WIDTH:0]    mag;
  logic              sum_neg;
  int                shamt;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (op_a_q[CHUNK-1:0]),
    .b    (op_b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  assign a_ext    = {2'b00, A};
  assign b_ext    = {2'b00, B};
  assign op_a_cap = control[1] ? (W2'(0) - a_ext) : a_ext;
  assign op_b_cap = control[0] ? (W2'(0) - b_ext) : b_ext;

  // cnt_q counts down, so the chunk being added is NCHUNK-1-cnt_q;
  // padding bits of the last chunk fall off the top of the sum.
  assign shamt   = ((NCHUNK - 1) - int'(cnt_q)) * CHUNK;
  assign sum_ins = W2'(PW'(chunk_s) << shamt);

  // |sum| < 2^(WIDTH+1), so the low WIDTH+1 bits are enough to negate.
  assign sum_neg = sum_q[W2-1];
  assign mag     = sum_neg ? (~sum_q[WIDTH:0] + (WIDTH+1)'(1)) : sum_q[WIDTH:0];

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    ill_op_d   = ill_op_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    c_d        = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d   = PW'(op_a_cap);
          op_b_d   = PW'(op_b_cap);
          sum_d    = '0;
          carry_d  = 1'b0;
          cnt_d    = CW'(NCHUNK - 1);
          ill_op_d = ~control[3];
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        op_a_d  = op_a_q >> CHUNK;
        op_b_d  = op_b_q >> CHUNK;
        sum_d   = sum_q | sum_ins;
        carry_d = chunk_cout;
        if (cnt_q == '0) begin
          state_d = ST_NORM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_NORM: begin
        illegal_d = ill_op_q;
        if (ill_op_q) begin
          sign_d     = 1'b0;
          overflow_d = 1'b0;
          c_d        = '0;
        end else begin
          sign_d     = sum_neg;
          overflow_d = mag[WIDTH];
`ifdef ADDSUB_SAT_EN
          c_d        = mag[WIDTH] ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
`else
          c_d        = mag[WIDTH-1:0];
`endif
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      ill_op_q   <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      c_q        <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      ill_op_q   <= ill_op_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      c_q        <= c_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign finish   = (state_q == ST_DONE);
  assign sign     = sign_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;
  assign C        = c_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: four instances (CHUNK 8/1/34 at WIDTH 32, CHUNK 3 at
// WIDTH 8) share stimulus and are compared against an integer reference model.
module tb_addsub_seq;
  import addsub_pkg::*;

  typedef struct packed {
    logic [31:0] c;
    logic        sign;
    logic        ovf;
    logic        ill;
  } res_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        sign;
    logic        ovf;
    logic        ill;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  control = 4'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;

  logic [3:0]  busy_v, fin_v, sign_v, ovf_v, ill_v;
  logic [31:0] c0, c1, c2;
  logic [7:0]  c3;
  logic [31:0] c_v [4];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int fin_cnt [4];
  int fin_cyc [4];
  res_t cap [4];
  int widths [4] = '{32, 32, 32, 8};
  int lat    [4] = '{6, 35, 2, 5};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clock(clock), .reset(reset), .start(start), .control(control), .A(a_in), .B(b_in),
    .busy(busy_v[0]), .finish(fin_v[0]), .sign(sign_v[0]), .overflow(ovf_v[0]),
    .illegal(ill_v[0]), .C(c0));
  addsub_seq #(.WIDTH(32), .CHUNK(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .control(control), .A(a_in), .B(b_in),
    .busy(busy_v[1]), .finish(fin_v[1]), .sign(sign_v[1]), .overflow(ovf_v[1]),
    .illegal(ill_v[1]), .C(c1));
  addsub_seq #(.WIDTH(32), .CHUNK(34)) dut2 (
    .clock(clock), .reset(reset), .start(start), .control(control), .A(a_in), .B(b_in),
    .busy(busy_v[2]), .finish(fin_v[2]), .sign(sign_v[2]), .overflow(ovf_v[2]),
    .illegal(ill_v[2]), .C(c2));
  addsub_seq #(.WIDTH(8), .CHUNK(3)) dut3 (
    .clock(clock), .reset(reset), .start(start), .control(control), .A(a_in[7:0]),
    .B(b_in[7:0]), .busy(busy_v[3]), .finish(fin_v[3]), .sign(sign_v[3]),
    .overflow(ovf_v[3]), .illegal(ill_v[3]), .C(c3));

  always_comb begin
    c_v[0] = c0;
    c_v[1] = c1;
    c_v[2] = c2;
    c_v[3] = {24'd0, c3};
  end

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (fin_v[i]) begin
        if (fin_cnt[i] == 0) begin
          fin_cyc[i] = cyc;
          cap[i] = '{c_v[i], sign_v[i], ovf_v[i], ill_v[i]};
        end
        fin_cnt[i]++;
      end
    end
  end

  // Reference: signed integer arithmetic on the operand values.
  function automatic res_t model(int w, logic [3:0] ctrl, logic [31:0] a, logic [31:0] b);
    res_t r;
    longint maxv, va, vb, s, mag;
    maxv = (longint'(1) <<< w) - 1;
    va = longint'(a) & maxv;
    vb = longint'(b) & maxv;
    if (ctrl[1]) va = -va;
    if (ctrl[0]) vb = -vb;
    s = va + vb;
    r = '{32'd0, 1'b0, 1'b0, 1'b0};
    if (!ctrl[3]) begin
      r.ill = 1'b1;
      return r;
    end
    r.sign = (s < 0);
    mag = (s < 0) ? -s : s;
    r.ovf = (mag > maxv);
`ifdef ADDSUB_SAT_EN
    r.c = r.ovf ? 32'(maxv) : 32'(mag & maxv);
`else
    r.c = 32'(mag & maxv);
`endif
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input bit repulse);
    int e0;
    bit all_done;
    res_t exp;
    @(negedge clock);
    control = ctrl;
    a_in = a;
    b_in = b;
    start = 1'b1;
    for (int i = 0; i < 4; i++) fin_cnt[i] = 0;
    @(posedge clock);
    #1;
    e0 = cyc;
    start = 1'b0;
    control = 4'($urandom);
    a_in = $urandom;
    b_in = $urandom;
    chk("busy_after_start", busy_v[0], 1);
    if (repulse) begin
      @(negedge clock);
      @(negedge clock);
      start = 1'b1;
      a_in = 32'd1;
      control = ADDNP;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    all_done = 1'b0;
    for (int k = 0; k < 80 && !all_done; k++) begin
      @(negedge clock);
      #1;
      all_done = (fin_cnt[0] > 0) && (fin_cnt[1] > 0) && (fin_cnt[2] > 0) && (fin_cnt[3] > 0);
    end
    @(negedge clock);
    @(negedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = model(widths[i], ctrl, a, b);
      chk($sformatf("finish_pulses[%0d]", i), fin_cnt[i], 1);
      chk($sformatf("latency[%0d]", i), fin_cyc[i] - e0, lat[i]);
      chk($sformatf("c[%0d] ctrl=%b a=%0h b=%0h", i, ctrl, a, b), cap[i].c, exp.c);
      chk($sformatf("sign[%0d] ctrl=%b a=%0h b=%0h", i, ctrl, a, b), cap[i].sign, exp.sign);
      chk($sformatf("overflow[%0d] ctrl=%b a=%0h b=%0h", i, ctrl, a, b), cap[i].ovf, exp.ovf);
      chk($sformatf("illegal[%0d]", i), cap[i].ill, exp.ill);
      chk($sformatf("hold_c[%0d]", i), c_v[i], exp.c);
      chk($sformatf("busy_idle[%0d]", i), busy_v[i], 0);
    end
  endtask

  vec_t vecs [7];
  logic [31:0] ra, rb;
  logic [3:0]  rc;
  int mode;

  initial begin
    vecs[0] = '{ADDPP, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{ADDPN, 32'd3, 32'd5, 32'd2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{ADDPN, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    vecs[3] = '{ADDNN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{ADDPP, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
`else
    vecs[3] = '{ADDNN, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{ADDPP, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0};
`endif
    vecs[4] = '{4'b0011, 32'd9, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{ADDNP, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 4; i++) fin_cnt[i] = 0;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy_v, 0);
    chk("reset_finish", fin_v, 0);
    chk("reset_sign", sign_v, 0);
    chk("reset_overflow", ovf_v, 0);
    chk("reset_illegal", ill_v, 0);
    chk("reset_c", c_v[0], 0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].ctrl, vecs[v].a, vecs[v].b, 1'b0);
      chk($sformatf("tbl_c[%0d]", v), cap[0].c, vecs[v].c);
      chk($sformatf("tbl_sign[%0d]", v), cap[0].sign, vecs[v].sign);
      chk($sformatf("tbl_overflow[%0d]", v), cap[0].ovf, vecs[v].ovf);
      chk($sformatf("tbl_illegal[%0d]", v), cap[0].ill, vecs[v].ill);
    end

    // start re-pulsed while busy must be ignored
    run_op(ADDNP, 32'd7, 32'd2, 1'b1);
    chk("repulse_c", cap[0].c, 5);
    chk("repulse_sign", cap[0].sign, 1);

    // reset in the middle of ADD
    @(negedge clock);
    control = ADDPP;
    a_in = 32'd5;
    b_in = 32'd3;
    start = 1'b1;
    for (int i = 0; i < 4; i++) fin_cnt[i] = 0;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", busy_v, 0);
    chk("abort_finish", fin_v, 0);
    chk("abort_sign", sign_v, 0);
    chk("abort_overflow", ovf_v, 0);
    chk("abort_illegal", ill_v, 0);
    chk("abort_c0", c_v[0], 0);
    chk("abort_c1", c_v[1], 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    chk("abort_no_finish", fin_cnt[0] + fin_cnt[1] + fin_cnt[2] + fin_cnt[3], 0);
    run_op(ADDPP, 32'd1, 32'd1, 1'b0);
    chk("post_reset_c", cap[0].c, 2);

    for (int n = 0; n < 40; n++) begin
      rc = {($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom)};
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 300); end
        2: begin ra = 32'hFFFF_FFFF - $urandom_range(0, 3); rb = $urandom; end
        default: begin ra = $urandom; rb = ra; end
      endcase
      run_op(rc, ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
